spram_16kx16: RTL and testbench
===============================

Name: spram_16kx16

Overview:
Single-port synchronous 16K x 16-bit RAM, behavioural equivalent of the iCE40UP SPRAM macro. The data cache instantiates two of them: one for the upper halfword of each 32-bit word and one for the lower halfword. Writes use nibble masks. Reads are registered with one-cycle latency.

Parameters:
ADDR_WIDTH, 14, word address width; depth = 2**ADDR_WIDTH = 16384 words
DATA_WIDTH, 16, word width; must be a multiple of 4
MASK_WIDTH, DATA_WIDTH/4 = 4, one write-enable bit per nibble

Ports:
CLOCK  input  1  single clock; all activity on rising edge
RESET_N  input  1  synchronous active-low reset
ADDRESS  input  ADDR_WIDTH  word address; narrower drivers are zero-extended by the instantiator
DATAIN  input  DATA_WIDTH  write data
MASKWREN  input  MASK_WIDTH  nibble write enables; bit i covers DATAIN[4i+3:4i]
WREN  input  1  1 = write cycle, 0 = read cycle
CHIPSELECT  input  1  1 = access enabled
DATAOUT  output  DATA_WIDTH  registered read data

Behaviour:
- Interface: one clock (CLOCK); reset is synchronous and active-low (RESET_N).
- Reset (RESET_N=0 at a rising edge):
  - DATAOUT <= 0.
  - Any write presented in that cycle is suppressed.
  - Array contents are not cleared.
  - Reset has priority over all other inputs.
- Array initial contents are undefined (X in simulation); the bench must write before reading.
- Idle (CHIPSELECT=0):
  - No array access.
  - DATAOUT holds its previous value.
- Read (CHIPSELECT=1, WREN=0): DATAOUT <= mem[ADDRESS] at the edge. Data is valid the cycle after the address is presented (latency 1).
- Write (CHIPSELECT=1, WREN=1):
  - For each i with MASKWREN[i]=1, mem[ADDRESS][4i+3:4i] <= DATAIN[4i+3:4i].
  - Nibbles with mask 0 are unchanged.
  - MASKWREN=0000 with WREN=1 is a legal no-op write.
  - DATAOUT holds its previous value during write cycles; there is no write-through.
- Write then read of the same address in the next cycle returns the new data (no hazard; the array updates at the write edge).
- Back-to-back reads at different addresses: each DATAOUT value follows its address by exactly one cycle.
- ADDRESS width is exact; there is no wrap-around or out-of-range case.
- ADDRESS, DATAIN and MASKWREN are don't-care when CHIPSELECT=0.

Optional Feature:
SPRAM_LOWPOWER_EN
- Defined: adds inputs STANDBY (1 bit) and SLEEP (1 bit), both active-high.
  - STANDBY=1 or SLEEP=1 blocks all reads and writes, as if CHIPSELECT=0.
  - While SLEEP=1, DATAOUT <= 0 each edge (synchronous).
  - While only STANDBY=1, DATAOUT holds.
  - Array contents are retained in both modes.
  - RESET_N keeps priority over both.
- Undefined: ports absent; behaviour as in Behaviour above.

Test Plan:
- Reset: RESET_N=0 for 2 cycles with CHIPSELECT=1, WREN=1, ADDRESS=5, DATAIN=16'hFFFF, MASKWREN=4'hF -> DATAOUT=0; a later read of address 5 shows the write did not occur (contents unchanged from before reset).
- Full write/read: write 16'hA5C3 to address 16'h3FFF with mask F; read it next cycle -> DATAOUT=16'hA5C3 one cycle after the read address.
- Nibble mask: write 16'h1234 to address 7 (mask F), then 16'hABCD with mask 4'b0101 -> read returns 16'h1B3D.
- Chip select: after a read leaves DATAOUT=16'h1B3D, drive CHIPSELECT=0 with WREN=1, DATAIN=0, mask F at address 7 -> DATAOUT stays 16'h1B3D; reread of address 7 still gives 16'h1B3D.
- Pipelined reads: addresses 0,1,2 written with 16'h0001, 16'h0002, 16'h0003; read 0,1,2 on consecutive cycles -> DATAOUT 0001, 0002, 0003 on the following three cycles. A write cycle inserted between reads holds DATAOUT.
- (SPRAM_LOWPOWER_EN) SLEEP=1 for one cycle during a read of address 7 -> DATAOUT=0 and no write occurs; after SLEEP=0, a read of address 7 returns 16'h1B3D.

Source files
------------

// File: rtl/spram_16kx16.sv
// Single-port 16K x 16 synchronous RAM with nibble write masks (iCE40UP SPRAM equivalent).
// Read latency 1 cycle. No backpressure; accepts one access every cycle. SPRAM_LOWPOWER_EN adds STANDBY/SLEEP.
module spram_16kx16 #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 16,
   parameter int MASK_WIDTH = DATA_WIDTH / 4
) (
   input  logic                  CLOCK,
   input  logic                  RESET_N,
   input  logic [ADDR_WIDTH-1:0] ADDRESS,
   input  logic [DATA_WIDTH-1:0] DATAIN,
   input  logic [MASK_WIDTH-1:0] MASKWREN,
   input  logic                  WREN,
   input  logic                  CHIPSELECT,
`ifdef SPRAM_LOWPOWER_EN
   input  logic                  STANDBY,
   input  logic                  SLEEP,
`endif
   output logic [DATA_WIDTH-1:0] DATAOUT
);

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

   logic                  access_en;
   logic                  rd_en;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] dataout_d;
   logic [DATA_WIDTH-1:0] dataout_q;

   always_comb begin
      access_en = CHIPSELECT;
`ifdef SPRAM_LOWPOWER_EN
      access_en = CHIPSELECT & ~STANDBY & ~SLEEP;
`endif
      rd_en = access_en & ~WREN;
      wr_en = access_en & WREN;

      dataout_d = dataout_q;
      if (rd_en) begin
         dataout_d = mem[ADDRESS];
      end
`ifdef SPRAM_LOWPOWER_EN
      if (SLEEP) begin
         dataout_d = '0;
      end
`endif
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         dataout_q <= '0;
      end else begin
         dataout_q <= dataout_d;
      end
   end

   // Array has no reset; reset only suppresses a write presented in the same cycle.
   always_ff @(posedge CLOCK) begin
      if (RESET_N && wr_en) begin
         for (int i = 0; i < MASK_WIDTH; i++) begin
            if (MASKWREN[i]) begin
               mem[ADDRESS][4*i +: 4] <= DATAIN[4*i +: 4];
            end
         end
      end
   end

   assign DATAOUT = dataout_q;

endmodule

// File: tb/tb_spram_16kx16.sv
// Directed plus randomized bench for spram_16kx16 against an array-based reference model.
module tb_spram_16kx16;

   logic        CLOCK;
   logic        RESET_N;
   logic [13:0] ADDRESS;
   logic [15:0] DATAIN;
   logic [3:0]  MASKWREN;
   logic        WREN;
   logic        CHIPSELECT;
   logic        STANDBY;
   logic        SLEEP;
   logic [15:0] DATAOUT;

`ifdef SPRAM_LOWPOWER_EN
   localparam bit LP = 1'b1;
`else
   localparam bit LP = 1'b0;
`endif

   spram_16kx16 dut (
      .CLOCK      (CLOCK),
      .RESET_N    (RESET_N),
      .ADDRESS    (ADDRESS),
      .DATAIN     (DATAIN),
      .MASKWREN   (MASKWREN),
      .WREN       (WREN),
      .CHIPSELECT (CHIPSELECT),
`ifdef SPRAM_LOWPOWER_EN
      .STANDBY    (STANDBY),
      .SLEEP      (SLEEP),
`endif
      .DATAOUT    (DATAOUT)
   );

   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   logic [15:0] model_mem [0:16383];
   logic [15:0] exp_out;
   int          vectors;
   int          miscompares;
   int          pool[$];

   // One clock cycle: drive inputs, let the edge happen, update the model, check DATAOUT.
   task automatic step(input logic rst_n, input logic cs, input logic we,
                       input logic [13:0] a, input logic [15:0] d, input logic [3:0] m,
                       input logic stby, input logic slp, input string tag);
      logic        blocked;
      logic [15:0] bitmask;
      RESET_N    = rst_n;
      CHIPSELECT = cs;
      WREN       = we;
      ADDRESS    = a;
      DATAIN     = d;
      MASKWREN   = m;
      STANDBY    = stby;
      SLEEP      = slp;
      @(posedge CLOCK);
      blocked = !cs || (LP && (stby || slp));
      if (!rst_n) begin
         exp_out = 16'h0000;
      end else begin
         if (LP && slp)
            exp_out = 16'h0000;
         else if (!blocked && !we)
            exp_out = model_mem[a];
         if (!blocked && we) begin
            bitmask = 16'h0000;
            for (int i = 0; i < 4; i++)
               if (m[i]) bitmask = bitmask | (16'hF << (4 * i));
            model_mem[a] = (model_mem[a] & ~bitmask) | (d & bitmask);
         end
      end
      #1;
      vectors++;
      assert (DATAOUT === exp_out) else begin
         miscompares++;
         $error("FAIL %s: DATAOUT=%h expected %h", tag, DATAOUT, exp_out);
      end
   endtask

   initial begin
      logic        r_rst, r_cs, r_we, r_sb, r_sl;
      logic [13:0] r_a;
      vectors     = 0;
      miscompares = 0;
      exp_out     = 16'h0000;
      RESET_N     = 1'b0;
      CHIPSELECT  = 1'b0;
      WREN        = 1'b0;
      ADDRESS     = '0;
      DATAIN      = '0;
      MASKWREN    = '0;
      STANDBY     = 1'b0;
      SLEEP       = 1'b0;

      step(0, 0, 0, 14'd0, 16'h0000, 4'h0, 0, 0, "reset_init");
      step(1, 1, 1, 14'd5, 16'h0F0F, 4'hF, 0, 0, "wr5_pre");
      step(1, 1, 0, 14'd5, 16'h0000, 4'h0, 0, 0, "rd5_pre");
      step(0, 1, 1, 14'd5, 16'hFFFF, 4'hF, 0, 0, "reset_wr_1");
      step(0, 1, 1, 14'd5, 16'hFFFF, 4'hF, 0, 0, "reset_wr_2");
      step(1, 1, 0, 14'd5, 16'h0000, 4'h0, 0, 0, "rd5_post_reset");

      step(1, 1, 1, 14'h3FFF, 16'hA5C3, 4'hF, 0, 0, "wr_top");
      step(1, 1, 0, 14'h3FFF, 16'h0000, 4'h0, 0, 0, "rd_top");

      step(1, 1, 1, 14'd7, 16'h1234, 4'hF, 0, 0, "wr7_full");
      step(1, 1, 1, 14'd7, 16'hABCD, 4'b0101, 0, 0, "wr7_mask");
      step(1, 1, 0, 14'd7, 16'h0000, 4'h0, 0, 0, "rd7_mask");
      step(1, 1, 1, 14'd7, 16'hFFFF, 4'h0, 0, 0, "wr7_nomask");
      step(1, 0, 1, 14'd7, 16'h0000, 4'hF, 0, 0, "cs_off_wr");
      step(1, 1, 0, 14'd7, 16'h0000, 4'h0, 0, 0, "rd7_after_cs");

      step(1, 1, 1, 14'd0, 16'h0001, 4'hF, 0, 0, "wr0");
      step(1, 1, 1, 14'd1, 16'h0002, 4'hF, 0, 0, "wr1");
      step(1, 1, 1, 14'd2, 16'h0003, 4'hF, 0, 0, "wr2");
      step(1, 1, 0, 14'd0, 16'h0000, 4'h0, 0, 0, "pipe_rd0");
      step(1, 1, 0, 14'd1, 16'h0000, 4'h0, 0, 0, "pipe_rd1");
      step(1, 1, 1, 14'd9, 16'h5555, 4'hF, 0, 0, "pipe_wr_hold");
      step(1, 1, 0, 14'd2, 16'h0000, 4'h0, 0, 0, "pipe_rd2");
      step(1, 1, 0, 14'd9, 16'h0000, 4'h0, 0, 0, "rd9");

`ifdef SPRAM_LOWPOWER_EN
      step(1, 1, 0, 14'd7, 16'h0000, 4'h0, 0, 1, "sleep_rd7");
      step(1, 1, 1, 14'd7, 16'h0000, 4'hF, 0, 1, "sleep_wr7");
      step(1, 1, 0, 14'd7, 16'h0000, 4'h0, 0, 0, "rd7_after_sleep");
      step(1, 1, 0, 14'h3FFF, 16'h0000, 4'h0, 1, 0, "standby_rd");
      step(1, 1, 1, 14'd7, 16'h0000, 4'hF, 1, 0, "standby_wr");
      step(1, 1, 0, 14'd7, 16'h0000, 4'h0, 0, 0, "rd7_after_standby");
      step(0, 1, 1, 14'd7, 16'h0000, 4'hF, 1, 1, "reset_over_lp");
`endif

      pool = '{0, 1, 2, 5, 7, 9, 16383};
      for (int k = 0; k < 10; k++) begin
         r_a = 14'($urandom);
         pool.push_back(int'(r_a));
         step(1, 1, 1, r_a, 16'($urandom), 4'hF, 0, 0, "rand_init");
      end

      for (int k = 0; k < 400; k++) begin
         r_rst = ($urandom_range(0, 31) != 0);
         r_cs  = ($urandom_range(0, 3) != 0);
         r_we  = 1'($urandom_range(0, 1));
         r_sb  = LP && ($urandom_range(0, 9) == 0);
         r_sl  = LP && ($urandom_range(0, 9) == 0);
         if (r_cs)
            r_a = 14'(pool[$urandom_range(0, pool.size() - 1)]);
         else
            r_a = 14'($urandom);
         step(r_rst, r_cs, r_we, r_a, 16'($urandom), 4'($urandom), r_sb, r_sl, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
